control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/microcode_rom.sv | 38 +++
 rtl/control_sequencer.sv | 73 +++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, control-word layout and step constants for the control sequencer
// Control word bit order, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
package cpu_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef logic [15:0] ctrl_word_t;

    localparam int STEPS = 5;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    localparam ctrl_word_t M_HLT = 16'h1 << B_HLT;
    localparam ctrl_word_t M_MI  = 16'h1 << B_MI;
    localparam ctrl_word_t M_RI  = 16'h1 << B_RI;
    localparam ctrl_word_t M_RO  = 16'h1 << B_RO;
    localparam ctrl_word_t M_IO  = 16'h1 << B_IO;
    localparam ctrl_word_t M_II  = 16'h1 << B_II;
    localparam ctrl_word_t M_AI  = 16'h1 << B_AI;
    localparam ctrl_word_t M_AO  = 16'h1 << B_AO;
    localparam ctrl_word_t M_EO  = 16'h1 << B_EO;
    localparam ctrl_word_t M_SU  = 16'h1 << B_SU;
    localparam ctrl_word_t M_BI  = 16'h1 << B_BI;
    localparam ctrl_word_t M_OI  = 16'h1 << B_OI;
    localparam ctrl_word_t M_CE  = 16'h1 << B_CE;
    localparam ctrl_word_t M_CO  = 16'h1 << B_CO;
    localparam ctrl_word_t M_J   = 16'h1 << B_J;
    localparam ctrl_word_t M_FI  = 16'h1 << B_FI;
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational microcode table mapping (opcode, step, cf, zf) to a control word
// Ports: opcode [3:0], step [2:0], cf, zf in; word [15:0] out (layout in cpu_ctrl_pkg)
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] step,
    input  logic       cf,
    input  logic       zf,
    output ctrl_word_t word
);
    always_comb begin
        word = '0;
        case (step)
            T0: word = M_MI | M_CO;
            T1: word = M_RO | M_II | M_CE;
            T2: case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: word = M_IO | M_MI;
                OP_LDI:  word = M_IO | M_AI;
                OP_JMP:  word = M_IO | M_J;
                OP_JC:   word = cf ? (M_IO | M_J) : '0;
                OP_JZ:   word = zf ? (M_IO | M_J) : '0;
                OP_OUT:  word = M_AO | M_OI;
                OP_HLT:  word = M_HLT;
                default: word = '0;
            endcase
            T3: case (opcode)
                OP_LDA:         word = M_RO | M_AI;
                OP_ADD, OP_SUB: word = M_RO | M_BI;
                OP_STA:         word = M_AO | M_RI;
                default:        word = '0;
            endcase
            T4: word = (opcode == OP_ADD || opcode == OP_SUB) ?
                       (M_EO | M_AI | M_FI | (opcode == OP_SUB ? M_SU : '0)) : '0;
            default: word = '0;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microstep counter, halt latch and prog/clr gating around the microcode ROM
// Ports: clk, clr (sync active-high), prog (1 = run), ir [N-1:0], cf, zf in;
//        sixteen control lines and step [2:0] (debug) out
module control_sequencer #(
    parameter int N     = 8,
    parameter int OPW   = 4,
    parameter int STEPS = cpu_ctrl_pkg::STEPS
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         prog,
    input  logic [N-1:0] ir,
    input  logic         cf,
    input  logic         zf,
    output logic         hlt,
    output logic         mi,
    output logic         ri,
    output logic         ro,
    output logic         io,
    output logic         ii,
    output logic         ai,
    output logic         ao,
    output logic         eo,
    output logic         su,
    output logic         bi,
    output logic         oi,
    output logic         ce,
    output logic         co,
    output logic         j,
    output logic         fi,
    output logic [2:0]   step
);
    logic [2:0] step_q;
    logic halted;
    logic run;
    logic unused;
    cpu_ctrl_pkg::ctrl_word_t word;
    cpu_ctrl_pkg::ctrl_word_t gated;

    assign unused = ^ir;

    microcode_rom u_rom (
        .opcode(4'(ir[N-1 -: OPW])),
        .step  (step_q),
        .cf    (cf),
        .zf    (zf),
        .word  (word)
    );

    // Outputs are live only while running; a latched halt keeps hlt up regardless of prog
    assign run   = !clr && prog && !halted;
    assign gated = run ? word : '0;
    assign hlt   = !clr && (halted || gated[cpu_ctrl_pkg::B_HLT]);
    assign {mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = gated[14:0];
    assign step  = clr ? 3'd0 : step_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            step_q <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (!prog)
                step_q <= '0;
            else if (word[cpu_ctrl_pkg::B_HLT])
                halted <= 1'b1;
            // an empty execute step ends the instruction immediately
            else if ((step_q >= cpu_ctrl_pkg::T2 && word == '0) || step_q == 3'(STEPS - 1))
                step_q <= '0;
            else
                step_q <= step_q + 3'd1;
        end
    end
endmodule
